// File: rtl/acc_label_scanner.sv
`timescale 1ns/1ps
// acc_label_scanner
//   Raster-side reader for the 32x16-dot "ACC" label bitmap ROM. Maps the
//   VGA pixel counters onto dot column/row addresses. It selects the left or
//   right 16-dot half of the ROM word. It then emits a registered label pixel
//   aligned with the delayed sync/blank signals. Magnification, blink and
//   inverse video are applied on the way through.
//
// Ports
//   clk, reset          pixel clock, asynchronous active-high reset
//   hcount, vcount      screen column / line from the timing generator
//   active_in           visible-region flag
//   hsync_in, vsync_in  active-high syncs
//   blink, inverse      flash the label / invert pixels inside the window
//   x, y                dot column / row address to the label ROM
//   pixell, pixelr      ROM pixel for columns 0-15 / 16-31
//   pixel_out           label pixel, aligned with active_out
//   active_out          active_in delayed 2 cycles
//   hsync_out           hsync_in delayed 2 cycles
//   vsync_out           vsync_in delayed 2 cycles
module acc_label_scanner #(
  parameter int unsigned X0         = 64,
  parameter int unsigned Y0         = 32,
  parameter int unsigned SCALE_LOG2 = 1,
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned BLINK_LOG2 = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] hcount,
  input  logic [CNT_W-1:0] vcount,
  input  logic             active_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             blink,
  input  logic             inverse,
  output logic [3:0]       x,
  output logic [3:0]       y,
  input  logic             pixell,
  input  logic             pixelr,
  output logic             pixel_out,
  output logic             active_out,
  output logic             hsync_out,
  output logic             vsync_out
);

  // Window bounds are held one bit wider than the counters so that a window
  // reaching the very end of the counter range cannot wrap.
  localparam logic [CNT_W:0]   X_LO = (CNT_W+1)'(X0);
  localparam logic [CNT_W:0]   X_HI = (CNT_W+1)'(X0 + (32 << SCALE_LOG2));
  localparam logic [CNT_W:0]   Y_LO = (CNT_W+1)'(Y0);
  localparam logic [CNT_W:0]   Y_HI = (CNT_W+1)'(Y0 + (16 << SCALE_LOG2));
  localparam logic [CNT_W-1:0] X0_V = CNT_W'(X0);
  localparam logic [CNT_W-1:0] Y0_V = CNT_W'(Y0);

  logic                  inwin;
  logic [4:0]            col;
  logic [3:0]            row;
  logic                  sel_r;
  logic                  inwin_q;
  logic                  active_q;
  logic                  hsync_q;
  logic                  vsync_q;
  logic [BLINK_LOG2-1:0] frame_cnt;
  logic                  hide;
  logic                  dot;

  // Compare before subtracting; the subtractions below only matter inside
  // the window, where they cannot underflow.
  always_comb begin
    inwin = ({1'b0, hcount} >= X_LO) && ({1'b0, hcount} < X_HI) &&
            ({1'b0, vcount} >= Y_LO) && ({1'b0, vcount} < Y_HI);
    col   = 5'((hcount - X0_V) >> SCALE_LOG2);
    row   = 4'((vcount - Y0_V) >> SCALE_LOG2);
  end

  // Stage 1: ROM address plus the delayed control bits. vsync_q doubles as
  // the previous-sample register for frame edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x         <= '0;
      y         <= '0;
      sel_r     <= 1'b0;
      inwin_q   <= 1'b0;
      active_q  <= 1'b0;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (inwin) begin
        x <= col[3:0];
        y <= row;
      end else begin
        x <= '0;
        y <= '0;
      end
      sel_r    <= col[4];
      inwin_q  <= inwin;
      active_q <= active_in;
      hsync_q  <= hsync_in;
      vsync_q  <= vsync_in;
      if (vsync_in && !vsync_q) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    hide = blink & frame_cnt[BLINK_LOG2-1];
    dot  = sel_r ? pixelr : pixell;
  end

  // Stage 2: the ROM has answered for the stage-1 address; gate and register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_out  <= 1'b0;
      active_out <= 1'b0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
    end else begin
      pixel_out  <= inwin_q & active_q & ~hide & (dot ^ inverse);
      active_out <= active_q;
      hsync_out  <= hsync_q;
      vsync_out  <= vsync_q;
    end
  end

endmodule
